// File: rtl/uart_pkg.sv
// Shared UART constants: default line timing, derived bit period and
// shifter state encoding, used by both the transmit and receive sides.
package uart_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int BAUD_DEFAULT   = 115_200;
  localparam int FRAME_BITS     = 10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Clocks per bit; truncation matches the receiver's sampling period.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int DIV_DEFAULT = baud_div(CLK_HZ_DEFAULT, BAUD_DEFAULT);

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with show-ahead read data; pushes into a full FIFO
// are ignored even when a pop happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: CPU writes fill a FIFO, the shifter drains
// it back-to-back and raises a sticky interrupt once the line goes idle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int BAUD   = BAUD_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       int_clr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       int_req
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [1:0]    state_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          int_req_reg;
  logic [7:0]    fifo_data;
  logic          bit_end;
  logic          pop;
  logic          int_set;
  logic          wr_accepted;

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .rd_data   (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bit_end      = (baud_cnt_reg == DIV_LAST);
  assign bit_idx_next = bit_idx_reg + 3'd1;
  // STOP hands straight over to the next queued byte, so there is no idle gap.
  assign pop          = ~fifo_empty & ((state_reg == IDLE) | ((state_reg == STOP) & bit_end));
  assign int_set      = (state_reg == STOP) & bit_end & fifo_empty;
  assign wr_accepted  = wr_en & ~fifo_full;

  assign tx      = tx_reg;
  assign int_req = int_req_reg;
  assign busy    = (state_reg != IDLE) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      int_req_reg  <= 1'b0;
    end else begin
      if (int_set) begin
        int_req_reg <= 1'b1;
      end else if (int_clr | wr_accepted) begin
        int_req_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          if (pop) begin
            shift_reg <= fifo_data;
            tx_reg    <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_next;
              tx_reg      <= shift_reg[bit_idx_next];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (pop) begin
              shift_reg <= fifo_data;
              tx_reg    <= 1'b0;
              state_reg <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-timeline model checks every output each
// cycle, a line decoder recovers the bytes, and literal checks pin the model.
module tb_uart_tx_fifo;

  localparam int DIV   = 434;   // 50e6 / 115200 truncated
  localparam int FDIV  = 10;    // 1e6 / 100e3
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst, wr_en, int_clr;
  logic [7:0] wr_data;
  logic       tx, busy, fifo_full, fifo_empty, int_req;
  logic       f_wr_en, f_int_clr;
  logic       f_tx, f_busy, f_full, f_empty, f_int_req;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rst_count = 0;
  int int_rises = 0;
  bit check_en = 0;
  bit fast_on  = 0;

  // Model: queued bytes, byte on the line and clocks since its start bit began.
  logic [7:0] m_q[$];
  logic [7:0] m_done[$];
  logic [7:0] rx_q[$];
  bit         m_active = 0;
  int         m_elapsed = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_int = 0;

  int exp55[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .int_clr    (int_clr),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .int_req    (int_req)
  );

  uart_tx_fifo #(
    .CLK_HZ (1000000),
    .BAUD   (100000),
    .DEPTH  (4)
  ) dut_fast (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (f_wr_en),
    .wr_data    (wr_data),
    .int_clr    (f_int_clr),
    .tx         (f_tx),
    .busy       (f_busy),
    .fifo_full  (f_full),
    .fifo_empty (f_empty),
    .int_req    (f_int_req)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int model_tx();
    int b;
    if (!m_active) return 1;
    b = m_elapsed / DIV;
    if (b == 0) return 0;
    if (b <= 8) return int'(m_cur[b-1]);
    return 1;
  endfunction

  task automatic model_step(input bit we, input logic [7:0] wd, input bit clr, input bit r);
    bit set_int;
    bit accepted;
    set_int = 0;
    if (r) begin
      m_q.delete();
      m_active  = 0;
      m_elapsed = 0;
      m_int     = 0;
      return;
    end
    accepted = we && (m_q.size() < DEPTH);
    if (m_active) begin
      m_elapsed++;
      if (m_elapsed == FRAME) begin
        m_done.push_back(m_cur);
        if (m_q.size() > 0) begin
          m_cur     = m_q.pop_front();
          m_elapsed = 0;
        end else begin
          m_active = 0;
          set_int  = 1;
        end
      end
    end else if (m_q.size() > 0) begin
      m_cur     = m_q.pop_front();
      m_active  = 1;
      m_elapsed = 0;
    end
    if (accepted) m_q.push_back(wd);
    if (set_int) m_int = 1;
    else if (clr || accepted) m_int = 0;
  endtask

  task automatic step(input bit we, input logic [7:0] wd, input bit clr, input bit r);
    rst     = r;
    wr_en   = we;
    wr_data = wd;
    int_clr = clr;
    f_wr_en = we & fast_on;
    @(posedge clk);
    model_step(we, wd, clr, r);
    if (r) rst_count++;
    cyc++;
    #1;
    rst     = 1'b0;
    wr_en   = 1'b0;
    int_clr = 1'b0;
    f_wr_en = 1'b0;
  endtask

  // Steps until the model line is idle, counting int_req rising edges.
  task automatic drain(input bit clr_at_end);
    int  guard;
    bit  clr;
    logic prev;
    guard = 0;
    prev  = int_req;
    while ((m_active || m_q.size() > 0) && guard < 8 * FRAME) begin
      clr = clr_at_end && m_active && (m_elapsed == FRAME - 1) && (m_q.size() == 0);
      step(0, 8'h00, clr, 0);
      if (int_req && !prev) int_rises++;
      prev = int_req;
      guard++;
    end
    step(0, 8'h00, 0, 0);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("tx", int'(tx), model_tx());
      check("busy", int'(busy), int'(m_active || m_q.size() > 0));
      check("fifo_full", int'(fifo_full), int'(m_q.size() == DEPTH));
      check("fifo_empty", int'(fifo_empty), int'(m_q.size() == 0));
      check("int_req", int'(int_req), int'(m_int));
    end
  end

  // Line decoder: samples mid-bit; frames cut by a reset are discarded.
  initial begin
    logic       prev;
    logic       start_bit;
    logic       stop_bit;
    logic [7:0] b;
    int         rc;
    prev = 1'b1;
    b    = 8'h00;
    forever begin
      @(negedge clk);
      if (check_en && prev && !tx) begin
        rc = rst_count;
        repeat (DIV / 2) @(negedge clk);
        start_bit = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        stop_bit = tx;
        if (rc == rst_count) begin
          check("rx_start", int'(start_bit), 0);
          check("rx_stop", int'(stop_bit), 1);
          rx_q.push_back(b);
          $display("rx byte 0x%02h at cycle %0d", b, cyc);
        end
      end
      prev = tx;
    end
  end

  initial begin
    int   bcnt;
    logic [7:0] exp3[3];
    int   burst_at;
    bit   we;
    rst = 1'b1; wr_en = 1'b0; int_clr = 1'b0; wr_data = 8'h00;
    f_wr_en = 1'b0; f_int_clr = 1'b0;
    exp3[0] = 8'hA3; exp3[1] = 8'h0F; exp3[2] = 8'hFF;

    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    check_en = 1;
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_full", int'(fifo_full), 0);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_int", int'(int_req), 0);
    check("rst_ftx", int'(f_tx), 1);

    // Single 0x55 frame on both instances
    fast_on = 1;
    step(1, 8'h55, 0, 0);
    fast_on = 0;
    $display("write 0x55 at cycle %0d", cyc);
    check("t55_nofall", int'(tx), 1);
    bcnt = int'(busy);
    for (int n = 1; n <= FRAME + 1; n++) begin
      step(0, 8'h00, 0, 0);
      if (busy) bcnt++;
      if (n == 1) check("t55_fall", int'(tx), 0);
      if (n < FRAME && (n % DIV) == DIV / 2) check("t55_bit", int'(tx), exp55[n / DIV]);
      if (n == FRAME) check("t55_int_lo", int'(int_req), 0);
      if (n == FRAME + 1) check("t55_int_hi", int'(int_req), 1);
      if (n <= 10 * FDIV) check("fast_bit", int'(f_tx), exp55[(n - 1) / FDIV]);
      if (n == 10 * FDIV) check("fast_int_lo", int'(f_int_req), 0);
      if (n == 10 * FDIV + 1) begin
        check("fast_idle", int'(f_tx), 1);
        check("fast_int_hi", int'(f_int_req), 1);
        check("fast_busy", int'(f_busy), 0);
      end
    end
    check("t55_busy_len", bcnt, 4341);
    step(0, 8'h00, 1, 0);
    check("clr_pulse", int'(int_req), 0);

    // Three back-to-back frames, single interrupt
    for (int i = 0; i < 3; i++) begin
      step(1, exp3[i], 0, 0);
      $display("write 0x%02h at cycle %0d", exp3[i], cyc);
    end
    int_rises = 0;
    drain(0);
    check("t3_int_rises", int_rises, 1);
    check("t3_int", int'(int_req), 1);
    check("t3_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 3; i++) check("t3_rx_byte", int'(rx_q[i+1]), int'(exp3[i]));

    step(1, 8'h96, 0, 0);
    $display("write 0x96 at cycle %0d", cyc);
    check("wr_clears_int", int'(int_req), 0);
    drain(1);
    check("set_beats_clr", int'(int_req), 1);

    // Six writes into a 4-deep FIFO: the sixth is dropped
    for (int i = 1; i <= 6; i++) begin
      step(1, 8'(i), 0, 0);
      $display("write 0x%02h at cycle %0d", i, cyc);
      if (i == 4) check("t6_not_full", int'(fifo_full), 0);
      if (i == 5) check("t6_full", int'(fifo_full), 1);
    end
    drain(0);
    check("t6_rx_count", rx_q.size(), 10);
    for (int i = 0; i < 5; i++) check("t6_rx_byte", int'(rx_q[i+5]), i + 1);

    // Reset in the middle of the data bits with two bytes queued
    step(1, 8'h3C, 0, 0);
    step(1, 8'hAA, 0, 0);
    step(1, 8'hBB, 0, 0);
    repeat (DIV * 4) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    $display("reset mid-frame at cycle %0d", cyc);
    check("mid_rst_tx", int'(tx), 1);
    check("mid_rst_empty", int'(fifo_empty), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_int", int'(int_req), 0);
    repeat (2800) step(0, 8'h00, 0, 0);
    check("mid_rst_rx_count", rx_q.size(), 10);

    // Random writes and acknowledges with one forced burst
    burst_at = $urandom_range(100, 2000);
    for (int k = 0; k < 8000; k++) begin
      we = ($urandom_range(0, 2999) == 0) || (k >= burst_at && k < burst_at + 5);
      step(we, 8'($urandom), ($urandom_range(0, 63) == 0), 0);
      if (we) $display("write 0x%02h at cycle %0d", wr_data, cyc);
    end
    drain(0);

    check("sb_count", rx_q.size(), m_done.size());
    for (int i = 0; i < rx_q.size() && i < m_done.size(); i++)
      check("sb_byte", int'(rx_q[i]), int'(m_done[i]));

    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
